xs_sound_cmd_mailbox: RTL

- Main-CPU to sound-CPU command mailbox and IRQ scheduler.
- Replaces the single sound latch and IRQ flip-flop with a small FIFO, so back-to-back main-CPU sound writes are not lost.
- Drives the sound CPU's data-mux latch source and its nIRQ.
- Re-arms IRQ after each read while commands remain queued.

---
 rtl/xs_snd_pkg.sv | 26 ++
 rtl/xs_sound_cmd_mailbox_if.sv | 33 +++
 rtl/xs_snd_cmd_fifo.sv | 84 ++++++++
 rtl/xs_sound_cmd_mailbox.sv | 86 ++++++++
 4 files changed

// File: rtl/xs_snd_pkg.sv
// Shared constants and width helpers for the sound-command mailbox.
package xs_snd_pkg;

  localparam int CMD_W       = 8;
  localparam int DEPTH_DEF   = 4;
  localparam int IRQ_GAP_DEF = 2;

  // Pointer width for a power-of-two FIFO depth.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Level width: one extra bit so a full FIFO is distinguishable from empty.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Gap counter width: must hold the value IRQ_GAP itself.
  function automatic int gap_w(input int gap);
    return (gap > 0) ? $clog2(gap + 1) : 1;
  endfunction

  localparam int PTR_W = ptr_w(DEPTH_DEF);
  localparam int LVL_W = lvl_w(DEPTH_DEF);

endpackage

// File: rtl/xs_sound_cmd_mailbox_if.sv
// Bus bundle between the main/sound CPU glue and the command mailbox.
interface xs_sound_cmd_mailbox_if
  import xs_snd_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
);

  localparam int LW = lvl_w(DEPTH);

  logic             wr_strobe_n;
  logic [CMD_W-1:0] db_in;
  logic             rd_cs_n;
  logic             rnw;
  logic             rd_cen;
  logic             flush;
  logic [CMD_W-1:0] cmd_out;
  logic             irq_n;
  logic             empty;
  logic             full;
  logic [LW-1:0]    level;
  logic             overflow;

  modport master (
    output wr_strobe_n, db_in, rd_cs_n, rnw, rd_cen, flush,
    input  cmd_out, irq_n, empty, full, level, overflow
  );

  modport slave (
    input  wr_strobe_n, db_in, rd_cs_n, rnw, rd_cen, flush,
    output cmd_out, irq_n, empty, full, level, overflow
  );

endinterface

// File: rtl/xs_snd_cmd_fifo.sv
// Synchronous command FIFO with flush, level count and a registered head.
// The head register follows mem[rd_ptr] one clock after any pointer or
// write change and holds the last popped byte while the FIFO is empty.
module xs_snd_cmd_fifo
  import xs_snd_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  input  logic [CMD_W-1:0]        din_i,
  output logic [CMD_W-1:0]        dout_o,
  output logic                    empty_o,
  output logic                    full_o,
  output logic [lvl_w(DEPTH)-1:0] level_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CMD_W-1:0] head_q, head_d;
  logic             empty_w, full_w;
  logic             do_push, do_pop;

  assign empty_w = (level_q == '0);
  assign full_w  = (level_q == LW'(DEPTH));

  // Qualify push/pop and compute next pointers, level and head.
  always_comb begin
    do_pop   = pop_i & ~empty_w & ~flush_i;
    do_push  = push_i & ~flush_i & (~full_w | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    head_d   = head_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      if (!empty_w) head_d = mem_q[rd_ptr_q];
    end
  end

  // Control state and head register; reset to empty with an all-ones head.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= {CMD_W{1'b1}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
    end
  end

  // Storage array, written on accepted pushes only; never reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = head_q;
  assign empty_o = empty_w;
  assign full_o  = full_w;
  assign level_o = level_q;

endmodule

// File: rtl/xs_sound_cmd_mailbox.sv
// Main-CPU to sound-CPU command mailbox: queues latch writes in a FIFO and
// raises the sound CPU's IRQ while commands are pending, with a short
// forced-high gap after each read so the ISR can reach RTI before re-entry.
module xs_sound_cmd_mailbox
  import xs_snd_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int IRQ_GAP = IRQ_GAP_DEF
) (
  input  logic                   clk,
  input  logic                   RSTn,
  xs_sound_cmd_mailbox_if.slave  bus
);

  localparam int LW = lvl_w(DEPTH);
  localparam int GW = gap_w(IRQ_GAP);

  logic             wr_q;
  logic [GW-1:0]    gap_q, gap_d;
  logic             irq_n_q, irq_n_d;
  logic             ovf_q, ovf_d;
  logic             push, pop;
  logic             fifo_empty, fifo_full;
  logic [LW-1:0]    fifo_level;
  logic [CMD_W-1:0] fifo_head;

  xs_snd_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (RSTn),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.flush),
    .din_i   (bus.db_in),
    .dout_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .level_o (fifo_level)
  );

  // Push detection, pop qualification, gap counter, IRQ and overflow next state.
  always_comb begin
    push    = ~wr_q & bus.wr_strobe_n;
    pop     = bus.rd_cen & ~bus.rd_cs_n & bus.rnw & ~fifo_empty;
    gap_d   = gap_q;
    ovf_d   = ovf_q;
    irq_n_d = ~(~fifo_empty & (gap_q == '0));
    if (bus.flush) begin
      gap_d   = '0;
      ovf_d   = 1'b0;
      irq_n_d = 1'b1;
    end else begin
      if (pop) begin
        gap_d   = GW'(IRQ_GAP);
        irq_n_d = 1'b1;
      end else if (bus.rd_cen && gap_q != '0) begin
        gap_d = gap_q - GW'(1);
      end
      if (push && fifo_full && !pop) ovf_d = 1'b1;
    end
  end

  // Control registers; the strobe history resets high so release cannot push.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      wr_q    <= 1'b1;
      gap_q   <= '0;
      irq_n_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= bus.wr_strobe_n;
      gap_q   <= gap_d;
      irq_n_q <= irq_n_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.cmd_out  = fifo_head;
  assign bus.irq_n    = irq_n_q;
  assign bus.empty    = fifo_empty;
  assign bus.full     = fifo_full;
  assign bus.level    = fifo_level;
  assign bus.overflow = ovf_q;

endmodule
